// File: rtl/serial_adder_n.sv
// Bit-serial adder: one full-adder step per clock through a single carry flop, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b via inverted b and forced carry-in).
module serial_adder_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_sh_reg, sum_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             carry_reg, cout_reg, ovf_reg;

   logic             accept, last_bit, bit_s, carry_next, invert_b, carry_load;
   logic [WIDTH-1:0] b_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign invert_b   = sub;
   assign carry_load = sub | cin;
`else
   assign invert_b   = 1'b0;
   assign carry_load = cin;
`endif

   // Subtraction is a + ~b + 1, so b is conditionally inverted bit by bit at load time.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_load
      assign b_load[gi] = b[gi] ^ invert_b;
   end

   assign accept     = start && (state_reg != RUN);
   assign last_bit   = (cnt_reg == CNT_W'(WIDTH - 1));
   assign bit_s      = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
   assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) |
                       (a_sh_reg[0] & carry_reg)   |
                       (b_sh_reg[0] & carry_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         sum_sh_reg <= '0;
         sum_reg    <= '0;
         cnt_reg    <= '0;
         carry_reg  <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else if (accept) begin
         a_sh_reg   <= a;
         b_sh_reg   <= b_load;
         sum_sh_reg <= '0;
         carry_reg  <= carry_load;
         cnt_reg    <= '0;
      end else if (state_reg == RUN) begin
         a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
         b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
         sum_sh_reg <= {bit_s, sum_sh_reg[WIDTH-1:1]};
         carry_reg  <= carry_next;
         cnt_reg    <= cnt_reg + CNT_W'(1);
         // On the MSB step carry_reg is the carry into the MSB, carry_next the carry out.
         if (last_bit) begin
            sum_reg  <= {bit_s, sum_sh_reg[WIDTH-1:1]};
            cout_reg <= carry_next;
            ovf_reg  <= carry_reg ^ carry_next;
         end
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: an 8-bit instance for directed scenarios and a
// 4-bit instance for an exhaustive sweep, both checked against a scoreboard queue.
module tb_serial_adder_n;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   logic       start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] sum4;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp8_t;

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       ovf;
   } exp4_t;

   exp8_t q8[$];
   exp4_t q4[$];

   always #5 clk = ~clk;

   serial_adder_n #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub8),
`endif
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8),
      .ovf   (ovf8)
   );

   serial_adder_n #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub4),
`endif
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4),
      .ovf   (ovf4)
   );

   // Reference: plain integer addition; subtraction as a + ~b + 1 with cin ignored.
   function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b,
                                    input logic cin, input logic sub);
      exp8_t      e;
      logic [7:0] bb;
      logic       c;
      logic [8:0] t;
      bb     = sub ? ~b : b;
      c      = sub ? 1'b1 : cin;
      t      = {1'b0, a} + {1'b0, bb} + {8'd0, c};
      e.sum  = t[7:0];
      e.cout = t[8];
      e.ovf  = (a[7] == bb[7]) && (t[7] != a[7]);
      return e;
   endfunction

   function automatic exp4_t model4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      exp4_t      e;
      logic [4:0] t;
      t      = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      e.sum  = t[3:0];
      e.cout = t[4];
      e.ovf  = (a[3] == b[3]) && (t[3] != a[3]);
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge with start low.
   task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub);
      q8.push_back(model8(a, b, cin, sub));
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // Waits for done (bounded); optionally re-pulses start with junk operands mid-run.
   task automatic wait8(input int pulse_at, output int lat, output logic [7:0] s,
                        output logic co, output logic ov, output int unstable);
      logic [7:0] held;
      held     = sum8;
      lat      = 0;
      unstable = 0;
      while (done8 !== 1'b1 && lat < 24) begin
         if (lat == pulse_at) begin
            start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
         end else begin
            start8 = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done8 !== 1'b1 && sum8 !== held) unstable++;
      end
      start8 = 1'b0;
      s  = sum8;
      co = cout8;
      ov = ovf8;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                  busy8, done8, sum8, cout8, ovf8);
      end
      checks++;
      if ({busy4, done4, sum4, cout4, ovf4} !== 8'd0) begin
         errors++;
         $display("FAIL reset4: got busy=%b done=%b sum=%h required all 0", busy4, done4, sum4);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy8, done8);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int         lat, unst;
      logic [7:0] s;
      logic       co, ov;
      exp8_t      e;
      launch8(8'h0F, 8'h01, 1'b0, 1'b0);
      checks++;
      if (busy8 !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b required 1", busy8);
      end
      wait8(-1, lat, s, co, ov, unst);
      e = q8.pop_front();
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d required 8", lat); end
      checks++;
      if ({s, co, ov} !== {e.sum, e.cout, e.ovf}) begin
         errors++;
         $display("FAIL basic_result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                  s, co, ov, e.sum, e.cout, e.ovf);
      end
      checks++;
      if (unst !== 0) begin errors++; $display("FAIL basic_sum_stable: got %0d changes required 0", unst); end
      checks++;
      if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b required 0", busy8); end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || sum8 !== 8'h10) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%b sum=%h required done=0 sum=10", done8, sum8);
      end
      $display("test_basic a=0f b=01 sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
   endtask

   task automatic test_carry_ovf();
      logic [7:0] ta[3] = '{8'hFF, 8'h7F, 8'h80};
      logic [7:0] tb[3] = '{8'h01, 8'h00, 8'h80};
      logic       tc[3] = '{1'b0, 1'b1, 1'b1};
      int         lat, unst;
      logic [7:0] s;
      logic       co, ov;
      exp8_t      e;
      for (int i = 0; i < 3; i++) begin
         launch8(ta[i], tb[i], tc[i], 1'b0);
         wait8(-1, lat, s, co, ov, unst);
         e = q8.pop_front();
         checks++;
         if ({s, co, ov} !== {e.sum, e.cout, e.ovf} || lat !== 8) begin
            errors++;
            $display("FAIL carry_ovf_%0d: got sum=%h cout=%b ovf=%b lat=%0d required sum=%h cout=%b ovf=%b lat=8",
                     i, s, co, ov, lat, e.sum, e.cout, e.ovf);
         end
         $display("test_carry_ovf a=%h b=%h cin=%b sum=%h cout=%b ovf=%b", ta[i], tb[i], tc[i], s, co, ov);
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int         lat, unst;
      logic [7:0] s;
      logic       co, ov;
      exp8_t      e;
      launch8(8'h12, 8'h34, 1'b0, 1'b0);
      wait8(3, lat, s, co, ov, unst);
      e = q8.pop_front();
      checks++;
      if (lat !== 8 || s !== e.sum || co !== e.cout || ov !== e.ovf) begin
         errors++;
         $display("FAIL ignore_start: got sum=%h lat=%0d required sum=%h lat=8", s, lat, e.sum);
      end
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_idle: got busy=%b done=%b required 0 0", busy8, done8);
      end
      $display("test_ignore_start sum=%h lat=%0d", s, lat);
   endtask

   task automatic test_back_to_back();
      int         lat, unst;
      logic [7:0] s;
      logic       co, ov;
      exp8_t      e;
      launch8(8'h40, 8'h02, 1'b0, 1'b0);
      wait8(-1, lat, s, co, ov, unst);
      e = q8.pop_front();
      checks++;
      if (s !== e.sum) begin errors++; $display("FAIL b2b_first: got %h required %h", s, e.sum); end
      launch8(8'h01, 8'h02, 1'b0, 1'b0);
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_bubble: got busy=%b done=%b required 1 0", busy8, done8);
      end
      wait8(-1, lat, s, co, ov, unst);
      e = q8.pop_front();
      checks++;
      if (lat !== 8 || s !== e.sum || co !== e.cout || ov !== e.ovf || unst !== 0) begin
         errors++;
         $display("FAIL b2b_second: got sum=%h lat=%0d changes=%0d required sum=%h lat=8 changes=0",
                  s, lat, unst, e.sum);
      end
      $display("test_back_to_back sum=%h lat=%0d", s, lat);
   endtask

   task automatic test_reset_midop();
      int         lat, unst, seen_done;
      logic [7:0] s;
      logic       co, ov;
      exp8_t      e;
      launch8(8'h33, 8'h44, 1'b0, 1'b0);
      e = q8.pop_back();  // this op is aborted, never completes
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
         errors++;
         $display("FAIL reset_midop: got busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                  busy8, done8, sum8, cout8, ovf8);
      end
      seen_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done8 === 1'b1) seen_done++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done8 === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses required 0", seen_done); end
      launch8(8'h10, 8'h20, 1'b0, 1'b0);
      wait8(-1, lat, s, co, ov, unst);
      e = q8.pop_front();
      checks++;
      if (lat !== 8 || s !== e.sum || co !== e.cout || ov !== e.ovf) begin
         errors++;
         $display("FAIL reset_recover: got sum=%h lat=%0d required sum=%h lat=8", s, lat, e.sum);
      end
      $display("test_reset_midop recovered sum=%h", s);
      @(negedge clk);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      logic [7:0] ta[3] = '{8'h05, 8'h80, 8'h33};
      logic [7:0] tb[3] = '{8'h07, 8'h01, 8'h11};
      logic       ts[3] = '{1'b1, 1'b1, 1'b0};
      int         lat, unst;
      logic [7:0] s;
      logic       co, ov;
      exp8_t      e;
      for (int i = 0; i < 3; i++) begin
         launch8(ta[i], tb[i], 1'b1, ts[i]);
         wait8(-1, lat, s, co, ov, unst);
         e = q8.pop_front();
         checks++;
         if ({s, co, ov} !== {e.sum, e.cout, e.ovf} || lat !== 8) begin
            errors++;
            $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     i, s, co, ov, e.sum, e.cout, e.ovf);
         end
         $display("test_sub sub=%b a=%h b=%h sum=%h cout=%b ovf=%b", ts[i], ta[i], tb[i], s, co, ov);
         @(negedge clk);
      end
      sub8 = 1'b0;
   endtask
`endif

   task automatic test_sweep4();
      int    lat, ops, bad;
      exp4_t e;
      ops = 0;
      bad = 0;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
               q4.push_back(model4(4'(ai), 4'(bi), 1'(ci)));
               @(posedge clk);
               @(negedge clk);
               start4 = 1'b0;
               lat = 0;
               while (done4 !== 1'b1 && lat < 12) begin
                  @(posedge clk);
                  lat++;
                  @(negedge clk);
               end
               e = q4.pop_front();
               checks++;
               if (lat !== 4) begin
                  errors++; bad++;
                  $display("FAIL sweep_latency a=%h b=%h cin=%0d: got %0d required 4", ai, bi, ci, lat);
               end
               checks++;
               if ({sum4, cout4, ovf4} !== {e.sum, e.cout, e.ovf}) begin
                  errors++; bad++;
                  $display("FAIL sweep_result a=%h b=%h cin=%0d: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                           ai, bi, ci, sum4, cout4, ovf4, e.sum, e.cout, e.ovf);
               end
               ops++;
               if (bad > 20) break;
            end
         end
      end
      $display("test_sweep4 ops=%0d bad=%0d", ops, bad);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_ovf();
      test_ignore_start();
      test_back_to_back();
      test_reset_midop();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_sweep4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
